pack_fifo: RTL
==============

Name: pack_fifo

Overview:
- Parametrised element-packing FIFO; next generation of the per-row ifmap/ipsum/opsum FIFOs between token_engine and conv_unit.
- Accepts either a full GLB word (LANES packed elements) or a single element per push, and delivers either a full word or a single element per pop.
- Provides occupancy, word-level space/availability flags, a synchronous clear, and sticky error flags.
- conv_unit instantiates one per PE row and channel type.

Parameters:
- WORD_W, 32, GLB word width in bits.
- ELEM_W, 8, element width in bits. WORD_W must be a multiple of ELEM_W. LANES = WORD_W/ELEM_W.
- DEPTH, 16, capacity in elements. Must be a power of 2 and >= LANES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; same role as the fifo_reset strobes.
- push_en_i  in  1  push request.
- push_mod_i  in  1  push mode: 1 = word push (LANES elements), 0 = single element from push_data_i[ELEM_W-1:0].
- push_data_i  in  WORD_W  push data; lane k occupies bits [k*ELEM_W +: ELEM_W]. Lane 0 is pushed first.
- pop_en_i  in  1  pop request.
- pop_mod_i  in  1  pop mode: 1 = word pop, 0 = single element pop.
- pop_data_o  out  WORD_W  show-ahead head data.
- count_o  out  $clog2(DEPTH)+1  number of stored elements.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- word_space_o  out  1  free space (DEPTH-count) >= LANES.
- word_avail_o  out  1  count >= LANES.
- ovf_err_o  out  1  sticky: a push was rejected.
- udf_err_o  out  1  sticky: a pop was rejected.

Behaviour:
- Reset and clear:
  - Reset (async, rst_n=0): read/write pointers = 0, count = 0, both error flags = 0. Storage contents are not reset.
  - Outputs after reset: empty_o=1, full_o=0, word_space_o=1, word_avail_o=0, pop_data_o=0.
  - clear_i=1: same effect as reset on the next edge, and overrides any push/pop issued in that cycle.
- Storage: DEPTH x ELEM_W array in circular form; pointers wrap modulo DEPTH.
- Push:
  - Required space: need_w = push_mod_i ? LANES : 1.
  - The push is accepted only if free space >= need_w, evaluated on the pre-edge state. A pop in the same cycle does not create space for it.
  - On accept: lane k is written to mem[wptr+k] for k < need_w, then wptr += need_w.
  - On reject: no change to storage or pointers; ovf_err_o is set to 1.
- Pop:
  - Required occupancy: need_r = pop_mod_i ? LANES : 1.
  - The pop is accepted only if count >= need_r, evaluated on the pre-edge state. A push in the same cycle does not supply data for it.
  - On accept: rptr += need_r. On reject: udf_err_o is set to 1.
- Simultaneous accepted push and pop: count_next = count + need_w - need_r.
- pop_data_o (combinational, show-ahead):
  - Lane k = mem[rptr+k] when k < count, otherwise 0.
  - When pop_mod_i=0, only lane 0 is valid and upper lanes are forced to 0.
  - Data must be sampled in the same cycle as the pop_en_i edge.
- Latency: a pushed element is visible on pop_data_o in the cycle after the push edge; there is no fall-through.
- Flags: all status outputs are combinational decodes of count. Error flags are cleared only by reset or clear_i.
- Wrap-around: a word push or pop that straddles the DEPTH-1 -> 0 boundary splits lanes across the boundary correctly.

Decomposition:
- Shared package fifo_pkg holds:
  - constants PUSH_ELEM=1'b0 and PUSH_WORD=1'b1;
  - localparam helper function lanes(WORD_W, ELEM_W).
- One natural sub-module: pack_fifo_mem. It is a DEPTH x ELEM_W register array with a LANES-wide write port and a LANES-wide read port, both taking a base address plus a lane mask and both wrapping modulo DEPTH.
- Pointer, count and flag logic stay in pack_fifo.

Test Plan:
1. Reset then word push 0xDDCCBBAA -> next cycle count_o=4, pop_data_o=0xDDCCBBAA, word_avail_o=1. Then word pop -> count_o=0, empty_o=1.
2. Element pushes 0x11, 0x22, 0x33 -> count_o=3, word_avail_o=0, pop_data_o(pop_mod=1)=0x00332211. Word pop rejected -> udf_err_o=1, count_o stays 3.
3. Fill with 4 word pushes (DEPTH=16) -> full_o=1, word_space_o=0. 5th push rejected -> ovf_err_o=1, contents unchanged.
4. Wrap-around:
   - 3 element pushes, 3 element pops, then 4 word pushes with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, filling the FIFO (count_o=16, full_o=1).
   - 4 word pops -> pop_data_o = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order.
   - The first of these words was written across lanes mem[3..6] and the fourth across lanes mem[15,0,1,2], so both the write and read paths straddle the DEPTH-1 -> 0 boundary.
5. count_o=13, simultaneous word push and element pop -> push rejected (free=3 < 4), pop accepted, count_o=12, ovf_err_o=1. Next cycle the same pair -> both accepted, count_o=15.
6. count_o=8, clear_i=1 together with push_en_i=1 -> next cycle count_o=0, error flags 0, no write. Assert rst_n=0 asynchronously mid-burst -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the element-packing FIFO family.
package fifo_pkg;

  // Push/pop mode encodings
  localparam logic PUSH_ELEM = 1'b0;
  localparam logic PUSH_WORD = 1'b1;
  localparam logic POP_ELEM  = 1'b0;
  localparam logic POP_WORD  = 1'b1;

  // Number of element lanes packed into one GLB word
  function automatic int lanes(input int word_w, input int elem_w);
    return word_w / elem_w;
  endfunction

endpackage

// File: rtl/pack_fifo_mem.sv
// DEPTH x ELEM_W circular storage with a LANES-wide masked write port and a
// LANES-wide masked combinational read port; both wrap modulo DEPTH.
module pack_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ELEM_W = 8,
  parameter int LANES  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_base_i,
  input  logic [LANES-1:0]        wr_mask_i,
  input  logic [LANES*ELEM_W-1:0] wr_data_i,
  input  logic [AW-1:0]           rd_base_i,
  input  logic [LANES-1:0]        rd_mask_i,
  output logic [LANES*ELEM_W-1:0] rd_data_o
);

  // Storage is deliberately not reset; pointers define what is valid.
  logic [ELEM_W-1:0] mem_q [DEPTH];

  // Write each enabled lane at base+lane; the AW-bit sum wraps naturally.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_mask_i[k]) begin
          mem_q[wr_base_i + AW'(k)] <= wr_data_i[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Show-ahead read: lane gi comes from base+gi, zeroed when masked off.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
      localparam logic [AW-1:0] LANE_OFF = AW'(gi);
      logic [AW-1:0] rd_addr;
      assign rd_addr = rd_base_i + LANE_OFF;
      assign rd_data_o[gi*ELEM_W +: ELEM_W] = rd_mask_i[gi] ? mem_q[rd_addr] : '0;
    end
  endgenerate

endmodule

// File: rtl/pack_fifo.sv
// Element-packing FIFO: word or single-element push/pop, show-ahead head,
// occupancy-derived status flags and sticky overflow/underflow errors.
module pack_fifo
  import fifo_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_en_i,
  input  logic                     push_mod_i,
  input  logic [WORD_W-1:0]        push_data_i,
  input  logic                     pop_en_i,
  input  logic                     pop_mod_i,
  output logic [WORD_W-1:0]        pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     word_space_o,
  output logic                     word_avail_o,
  output logic                     ovf_err_o,
  output logic                     udf_err_o
);

  localparam int LANES = lanes(WORD_W, ELEM_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [CW-1:0] need_w, need_r, free_w;
  logic          push_ok, pop_ok;
  logic [LANES-1:0] wr_mask, rd_mask;

  // Acceptance is judged on the pre-edge occupancy only, so a same-cycle
  // pop never frees room for a push and a push never feeds a pop.
  assign need_w  = (push_mod_i == PUSH_WORD) ? CW'(LANES) : CW'(1);
  assign need_r  = (pop_mod_i == POP_WORD) ? CW'(LANES) : CW'(1);
  assign free_w  = CW'(DEPTH) - count_q;
  assign push_ok = push_en_i && (free_w >= need_w);
  assign pop_ok  = pop_en_i && (count_q >= need_r);

  // Lane masks: write the lanes being pushed; read only stored lanes, and
  // only lane 0 when the consumer asked for a single element.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign wr_mask[gi] = (CW'(gi) < need_w);
      assign rd_mask[gi] = (CW'(gi) < count_q) && ((pop_mod_i == POP_WORD) || (gi == 0));
    end
  endgenerate

  // Next-state for pointers, occupancy and sticky errors; clear wins.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + need_w[AW-1:0];
      end else if (push_en_i) begin
        ovf_d = 1'b1;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + need_r[AW-1:0];
      end else if (pop_en_i) begin
        udf_d = 1'b1;
      end
      count_d = count_q + (push_ok ? need_w : '0) - (pop_ok ? need_r : '0);
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  pack_fifo_mem #(
    .DEPTH  (DEPTH),
    .ELEM_W (ELEM_W),
    .LANES  (LANES)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_ok && !clear_i),
    .wr_base_i (wptr_q),
    .wr_mask_i (wr_mask),
    .wr_data_i (push_data_i),
    .rd_base_i (rptr_q),
    .rd_mask_i (rd_mask),
    .rd_data_o (pop_data_o)
  );

  assign count_o      = count_q;
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign word_space_o = (free_w >= CW'(LANES));
  assign word_avail_o = (count_q >= CW'(LANES));
  assign ovf_err_o    = ovf_q;
  assign udf_err_o    = udf_q;

endmodule
